// File: rtl/move_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : move_packer_pkg
// Brief   : Shared widths, word constants and FSM state encoding for the
//           move packer and its word FIFO.
// Revision: 1.0 - initial release
// ============================================================================
package move_packer_pkg;

  localparam int MOVE_W     = 18;
  localparam int SLOT_W     = 19;
  localparam int SLOTS      = 8;
  localparam int WORD_W     = 152;
  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = 3;
  localparam int CNT_W      = 4;

  // One slot with only its invalid flag (top bit) set.
  localparam logic [SLOT_W-1:0] INVALID_SLOT     = 19'h40000;
  // Every slot invalid: used as terminator and as the idle output value.
  localparam logic [WORD_W-1:0] ALL_INVALID_WORD = {SLOTS{INVALID_SLOT}};

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_TERM    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // A valid slot carries the move with the invalid flag cleared.
  function automatic logic [SLOT_W-1:0] make_slot(input logic [MOVE_W-1:0] mv);
    return {1'b0, mv};
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_word_fifo.sv
`default_nettype none
// ============================================================================
// Module  : move_word_fifo
// Brief   : Synchronous FIFO of packed move words. Push is ignored when full,
//           pop is ignored when empty (both judged on pre-edge state).
//           Storage is not reset; only pointers and count are.
// Revision: 1.0 - initial release
// ============================================================================
module move_word_fifo
  import move_packer_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; clear drops all stored words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Word storage, intentionally without reset.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/move_packer.sv
`default_nettype none
// ============================================================================
// Module  : move_packer
// Brief   : Packs 18-bit moves into 152-bit words of eight 19-bit slots,
//           flushes a padded partial word at end of generation, appends an
//           all-invalid terminator word and signals done.
// Revision: 1.0 - initial release
// ============================================================================
module move_packer
  import move_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              move_valid,
  input  logic [MOVE_W-1:0] move_data,
  output logic              move_ready,
  input  logic              gen_done,
  input  logic              rden,
  output logic [WORD_W-1:0] fifoOut,
  output logic              done
);

  localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);

  logic [1:0]        r_state;
  logic [2:0]        r_slot_cnt;
  logic [WORD_W-1:0] r_word_buf;
  logic [WORD_W-1:0] r_fifo_out;

  logic              w_accept;
  logic              w_push;
  logic [WORD_W-1:0] w_push_data;
  logic [WORD_W-1:0] w_completed_word;
  logic [WORD_W-1:0] w_flush_word;
  logic [WORD_W-1:0] w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_has_room;

  // A move landing in the last slot needs a free FIFO entry on the same edge.
  assign move_ready = (r_state == ST_COLLECT) && !((r_slot_cnt == LAST_SLOT) && w_fifo_full);
  assign w_accept   = move_valid && move_ready;
  assign w_has_room = (w_fifo_count < CNT_W'(FIFO_DEPTH));
  assign done       = (r_state == ST_DONE);
  assign fifoOut    = r_fifo_out;

  // Select what, if anything, is pushed into the FIFO this cycle.
  always_comb begin
    w_completed_word = r_word_buf;
    w_completed_word[(SLOTS-1)*SLOT_W +: SLOT_W] = make_slot(move_data);
    w_flush_word = r_word_buf;
    for (int k = 0; k < SLOTS; k++) begin
      if (k >= int'(r_slot_cnt)) w_flush_word[k*SLOT_W +: SLOT_W] = INVALID_SLOT;
    end
    w_push      = 1'b0;
    w_push_data = w_completed_word;
    case (r_state)
      ST_COLLECT: begin
        if (w_accept && (r_slot_cnt == LAST_SLOT)) w_push = 1'b1;
      end
      ST_FLUSH: begin
        if ((r_slot_cnt != 3'd0) && w_has_room) begin
          w_push      = 1'b1;
          w_push_data = w_flush_word;
        end
      end
      ST_TERM: begin
        if (w_has_room) begin
          w_push      = 1'b1;
          w_push_data = ALL_INVALID_WORD;
        end
      end
      default: ;
    endcase
  end

  // Packing state machine: collect moves, flush partial word, terminate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_COLLECT;
      r_slot_cnt <= 3'd0;
      r_word_buf <= '0;
    end else if (clear) begin
      r_state    <= ST_COLLECT;
      r_slot_cnt <= 3'd0;
      r_word_buf <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (r_slot_cnt == LAST_SLOT) r_word_buf <= '0;
            else r_word_buf[r_slot_cnt*SLOT_W +: SLOT_W] <= make_slot(move_data);
            r_slot_cnt <= r_slot_cnt + 3'd1;
          end
          // The move accepted alongside gen_done is already packed above.
          if (gen_done) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (r_slot_cnt == 3'd0) begin
            r_state <= ST_TERM;
          end else if (w_has_room) begin
            r_slot_cnt <= 3'd0;
            r_word_buf <= '0;
            r_state    <= ST_TERM;
          end
        end
        ST_TERM: begin
          if (w_has_room) r_state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // Output register: head word on a pop, all-invalid word when nothing to pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fifo_out <= ALL_INVALID_WORD;
    end else if (clear) begin
      r_fifo_out <= ALL_INVALID_WORD;
    end else if (rden) begin
      r_fifo_out <= w_fifo_empty ? ALL_INVALID_WORD : w_head;
    end
  end

  move_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (rden),
    .head      (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_move_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_move_packer
// Brief   : Self-checking bench for move_packer: directed scenarios plus
//           randomized sequences against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_move_packer;
  import move_packer_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              move_valid;
  logic [MOVE_W-1:0] move_data;
  logic              move_ready;
  logic              gen_done;
  logic              rden;
  logic [WORD_W-1:0] fifoOut;
  logic              done;

  always #5 clk = ~clk;

  move_packer dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .move_valid (move_valid),
    .move_data  (move_data),
    .move_ready (move_ready),
    .gen_done   (gen_done),
    .rden       (rden),
    .fifoOut    (fifoOut),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words waiting in the FIFO, moves of the open word,
  // phase 0..3 = collecting, flushing, terminating, finished.
  logic [WORD_W-1:0] m_words[$];
  logic [MOVE_W-1:0] m_pend[$];
  int                m_phase;
  logic [WORD_W-1:0] m_out;
  logic              acc;

  task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] pack_pending();
    logic [WORD_W-1:0] w;
    w = ALL_INVALID_WORD;
    for (int k = 0; k < m_pend.size(); k++) w[k*SLOT_W +: SLOT_W] = {1'b0, m_pend[k]};
    return w;
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_pend.delete();
    m_phase = 0;
    m_out   = ALL_INVALID_WORD;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input logic v, input logic [MOVE_W-1:0] d, input logic gd,
                       input logic rd, input logic clr, output logic accepted);
    logic exp_ready;
    logic full_pre;
    move_valid = v;
    move_data  = d;
    gen_done   = gd;
    rden       = rd;
    clear      = clr;
    exp_ready  = (m_phase == 0) && !(m_pend.size() == 7 && m_words.size() == FIFO_DEPTH);
    accepted   = v && exp_ready && !clr;
    #1;
    check("move_ready", WORD_W'(move_ready), WORD_W'(exp_ready));
    @(posedge clk);
    full_pre = (m_words.size() == FIFO_DEPTH);
    if (clr) begin
      model_reset();
    end else begin
      if (rd) m_out = (m_words.size() > 0) ? m_words.pop_front() : ALL_INVALID_WORD;
      case (m_phase)
        0: begin
          if (v && exp_ready) begin
            m_pend.push_back(d);
            if (m_pend.size() == SLOTS) begin
              m_words.push_back(pack_pending());
              m_pend.delete();
            end
          end
          if (gd) m_phase = 1;
        end
        1: begin
          if (m_pend.size() == 0) m_phase = 2;
          else if (!full_pre) begin
            m_words.push_back(pack_pending());
            m_pend.delete();
            m_phase = 2;
          end
        end
        2: if (!full_pre) begin
          m_words.push_back(ALL_INVALID_WORD);
          m_phase = 3;
        end
        default: ;
      endcase
    end
    #1;
    check("fifoOut", fifoOut, m_out);
    check("done", WORD_W'(done), WORD_W'(m_phase == 3));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic do_clear();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Offer moves base+1..base+n, each held until accepted (bounded).
  task automatic send_moves(input int n, input int base);
    for (int i = 1; i <= n; i++) begin
      int tries;
      tries = 0;
      do begin
        cycle(1'b1, MOVE_W'(base + i), 1'b0, 1'b0, 1'b0, acc);
        tries++;
      end while (!acc && tries < 50);
      if (!acc) check("send_timeout", WORD_W'(0), WORD_W'(1));
    end
  endtask

  // Pop until the model has produced everything, then one extra pop.
  task automatic drain();
    int cyc;
    cyc = 0;
    while (!(m_phase == 3 && m_words.size() == 0) && cyc < 60) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
      cyc++;
    end
    check("drain_bound", WORD_W'(m_phase == 3 && m_words.size() == 0), WORD_W'(1));
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    check("empty_pop", fifoOut, ALL_INVALID_WORD);
  endtask

  task automatic async_reset();
    @(negedge clk);
    move_valid = 1'b0; gen_done = 1'b0; rden = 1'b0; clear = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_fifoOut", fifoOut, ALL_INVALID_WORD);
    check("rst_done", WORD_W'(done), WORD_W'(0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [MOVE_W-1:0] cur;
    int target, sent, cyc;
    reset = 1'b0; clear = 1'b0; move_valid = 1'b0; move_data = '0;
    gen_done = 1'b0; rden = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out", fifoOut, ALL_INVALID_WORD);
    check("reset_done", WORD_W'(done), WORD_W'(0));
    reset = 1'b1;

    // Full word then terminator.
    send_moves(8, 0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    idle(3);
    drain();

    // Partial word of three moves.
    do_clear();
    send_moves(3, 16'h100);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    idle(3);
    drain();

    // No moves at all: terminator only.
    do_clear();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    idle(3);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

    // Backpressure: keep offering moves with no pops, then pop while stalled.
    do_clear();
    cur = 18'h2000;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, cur, 1'b0, 1'b0, 1'b0, acc);
      if (acc) cur = cur + 1'b1;
    end
    check("stalled_ready", WORD_W'(move_ready), WORD_W'(0));
    cycle(1'b1, cur, 1'b0, 1'b1, 1'b0, acc);
    if (acc) cur = cur + 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, cur, 1'b0, 1'b0, 1'b0, acc);
      if (acc) cur = cur + 1'b1;
    end
    // Last move offered together with gen_done.
    cycle(1'b1, cur, 1'b1, 1'b1, 1'b0, acc);
    drain();

    // Move in the same cycle as gen_done.
    do_clear();
    send_moves(2, 18'h3000);
    cycle(1'b1, 18'h3ABCD, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Clear after five moves, then a fresh short sequence.
    do_clear();
    send_moves(5, 18'h400);
    do_clear();
    check("clr_out", fifoOut, ALL_INVALID_WORD);
    send_moves(3, 18'h500);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Asynchronous reset after five moves, then a fresh sequence.
    do_clear();
    send_moves(5, 18'h600);
    async_reset();
    send_moves(2, 18'h700);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Randomized sequences with random pops and stray gen_done pulses.
    for (int s = 0; s < 8; s++) begin
      do_clear();
      target = $urandom_range(0, 40);
      sent = 0;
      cyc = 0;
      cur = MOVE_W'($urandom);
      while (!(m_phase == 3 && m_words.size() == 0) && cyc < 600) begin
        logic v, rd, gd;
        v  = (sent < target) && ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 2) == 0);
        gd = ((sent == target) && ($urandom_range(0, 1) == 0)) || ($urandom_range(0, 30) == 0 && m_phase != 0);
        cycle(v, cur, gd, rd, 1'b0, acc);
        if (acc) begin
          sent++;
          cur = MOVE_W'($urandom);
        end
        cyc++;
      end
      check("rand_bound", WORD_W'(m_phase == 3 && m_words.size() == 0), WORD_W'(1));
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
